// File: rtl/aes_128_decrypt_iter.sv
// aes_128_decrypt_iter: iterative AES-128 ECB decryptor, one inverse round per clk,
// round keys generated on the fly with a one-entry cache of the last expanded key
module aes_128_decrypt_iter #(
  parameter int NR = 10,
  parameter int BYTES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*BYTES-1:0]   in_key,
  input  logic [8*BYTES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*BYTES-1:0]   out_data,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, KEYX, ROUND, DONE} st_t;
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  // inverse S-box is the forward table inverted at elaboration, so only one table is hand-entered
  function automatic logic [2047:0] mk_isbox();
    logic [2047:0] r = '0;
    for (int i = 0; i < 256; i++) r[{SBOX[i], 3'b000} +: 8] = 8'(i);
    return r;
  endfunction
  localparam logic [2047:0] ISBOX = mk_isbox();
  function automatic logic [7:0] isb(input logic [7:0] x);
    return ISBOX[{x, 3'b000} +: 8];
  endfunction
  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    return {w0, w1, w2, k[31:0] ^ w2};
  endfunction
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3;
    w3 = k[31:0] ^ k[63:32];
    return {k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0}, k[95:64] ^ k[127:96], k[63:32] ^ k[95:64], w3};
  endfunction
  // internal state is FIPS-197 ordered: byte 4c+r (row r, column c) at bits [127-8b -: 8]
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        r[127-8*(4*c+j) -: 8] = isb(s[127-8*(4*((c-j)&3)+j) -: 8]);
    return r;
  endfunction
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        a[j] = s[127-8*(4*c+j) -: 8];
        x2[j] = xt(a[j]);
        x4[j] = xt(x2[j]);
        x8[j] = xt(x4[j]);
      end
      for (int j = 0; j < 4; j++)
        r[127-8*(4*c+j) -: 8] = (x8[j] ^ x4[j] ^ x2[j]) ^ (x8[(j+1)&3] ^ x2[(j+1)&3] ^ a[(j+1)&3]) ^
                                (x8[(j+2)&3] ^ x4[(j+2)&3] ^ a[(j+2)&3]) ^ (x8[(j+3)&3] ^ a[(j+3)&3]);
    end
    return r;
  endfunction
  st_t st_q, st_d;
  logic [127:0] blk_q, blk_d, wk_q, wk_d, ckey_q, ckey_d, crk_q, crk_d, out_q, out_d;
  logic [3:0] cnt_q, cnt_d;
  logic cval_q, cval_d;
  logic [127:0] rk_f, rk_b, sb;
  logic hit;
  assign rk_f = key_fwd(wk_q, RCON[cnt_q]);
  assign rk_b = key_inv(wk_q, RCON[cnt_q + 4'd1]);
  assign sb = inv_sr_sb(blk_q);
  assign hit = cval_q && in_key == ckey_q;
  assign in_ready = st_q == IDLE;
  assign busy = st_q != IDLE;
  assign out_valid = st_q == DONE;
  assign out_data = out_q;
  always_comb begin
    st_d = st_q;
    blk_d = blk_q;
    wk_d = wk_q;
    cnt_d = cnt_q;
    ckey_d = ckey_q;
    crk_d = crk_q;
    cval_d = cval_q;
    out_d = out_q;
    case (st_q)
      IDLE: if (in_valid) begin
        st_d = hit ? ROUND : KEYX;
        blk_d = bswap(in_data) ^ (hit ? crk_q : '0);
        wk_d = hit ? crk_q : bswap(in_key);
        cnt_d = hit ? 4'(NR - 1) : 4'd1;
        ckey_d = in_key;
        cval_d = hit;
      end
      KEYX: begin
        wk_d = rk_f;
        cnt_d = cnt_q == 4'(NR) ? 4'(NR - 1) : cnt_q + 4'd1;
        if (cnt_q == 4'(NR)) begin
          crk_d = rk_f;
          cval_d = 1'b1;
          blk_d = blk_q ^ rk_f;
          st_d = ROUND;
        end
      end
      ROUND: begin
        wk_d = rk_b;
        cnt_d = cnt_q - 4'd1;
        blk_d = inv_mix(sb ^ rk_b);
        if (cnt_q == 4'd0) begin
          out_d = bswap(sb ^ rk_b);
          st_d = DONE;
        end
      end
      DONE: st_d = out_ready ? IDLE : DONE;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      blk_q <= '0;
      wk_q <= '0;
      cnt_q <= '0;
      ckey_q <= '0;
      crk_q <= '0;
      cval_q <= 1'b0;
      out_q <= '0;
    end else begin
      st_q <= st_d;
      blk_q <= blk_d;
      wk_q <= wk_d;
      cnt_q <= cnt_d;
      ckey_q <= ckey_d;
      crk_q <= crk_d;
      cval_q <= cval_d;
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_aes_128_decrypt_iter.sv
// tb_aes_128_decrypt_iter: known-answer vectors, cache hit/miss latency, backpressure,
// ignored input outside IDLE, random round trips against a forward AES model, mid-run reset
module tb_aes_128_decrypt_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [127:0] in_key = '0;
  logic [127:0] in_data = '0;
  logic in_ready, out_valid, busy;
  logic [127:0] out_data;

  always #5 clk = ~clk;

  aes_128_decrypt_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  typedef struct { logic [127:0] key; logic [127:0] ct; logic [127:0] pt; } vec_t;
  typedef struct { logic [127:0] pt; int lat; string nm; } exp_t;
  exp_t sbq[$];
  int n_chk = 0;
  int n_pass = 0;
  logic cv = 1'b0;
  logic [127:0] ck = '0;
  logic [7:0] sb [256];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
  endfunction

  // FIPS text order (byte 0 leftmost) to port order (byte 0 on [7:0])
  function automatic logic [127:0] to_port(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [31:0] tmp;
    logic [7:0] rc;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[4*((b/4 + b%4) % 4) + b%4]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          s[4*c+j] = (rnd == 10 ? t[4*c+j] : xt(t[4*c+j]) ^ xt(t[4*c+(j+1)%4]) ^ t[4*c+(j+1)%4] ^
                      t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4]) ^ w[4*rnd+c][31-8*j -: 8];
    end
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = s[b];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input logic [127:0] kf, input logic [127:0] cf, input logic [127:0] pf,
                           input string nm, input int hold, input int junk_at);
    exp_t e;
    int w, lat, bad;
    logic [127:0] kp, d0;
    kp = to_port(kf);
    e.pt = to_port(pf);
    e.lat = (cv && kp == ck) ? 10 : 20;
    e.nm = nm;
    sbq.push_back(e);
    cv = 1'b1;
    ck = kp;
    out_ready = (hold == 0);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_key = kp;
    in_data = to_port(cf);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_key = rnd128();
    in_data = rnd128();
    chk({nm, "_busy"}, 128'(busy), 128'(1));
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (junk_at > 0 && lat == junk_at) begin
        in_valid = 1'b1;
        in_key = ~kp;
        in_data = rnd128();
      end
      if (junk_at > 0 && lat == junk_at + 3) begin
        chk({nm, "_junk_ready"}, 128'(in_ready), 128'(0));
        in_valid = 1'b0;
      end
    end
    e = sbq.pop_front();
    chk({e.nm, "_latency"}, 128'(lat), 128'(e.lat));
    chk({e.nm, "_data"}, out_data, e.pt);
    d0 = out_data;
    if (hold > 0) begin
      bad = 0;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (!out_valid || out_data !== d0 || in_ready || !busy) bad++;
      end
      chk({e.nm, "_hold_unstable_cycles"}, 128'(bad), 128'(0));
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({e.nm, "_release_valid_ready_busy"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
    chk({e.nm, "_keep"}, out_data, d0);
  endtask

  initial begin
    vec_t tv [6];
    logic [7:0] p, q;
    logic [127:0] pool [2];
    logic [127:0] k, pt;
    tv[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    tv[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    tv[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
    tv[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
    tv[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
    tv[5] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
    // S-box from the multiplicative-inverse/affine construction, walking GF(2^8) by powers of 3
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;

    repeat (3) @(negedge clk);
    chk("reset_out_data", out_data, 128'h0);
    chk("reset_valid_ready_busy", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_block(tv[i].key, tv[i].ct, tv[i].pt, $sformatf("vec%0d", i), 0, 0);
    run_block(tv[0].key, tv[0].ct, tv[0].pt, "backpressure", 50, 0);
    run_block(tv[2].key, tv[2].ct, tv[2].pt, "junk_in_round", 0, 13);
    run_block(tv[2].key, tv[2].ct, tv[2].pt, "after_junk_hit", 0, 0);

    pool[0] = rnd128();
    pool[1] = rnd128();
    for (int i = 0; i < 1000; i++) begin
      k = (i % 8 == 7) ? rnd128() : pool[(i >> 1) & 1];
      pt = rnd128();
      run_block(k, enc(k, pt), pt, $sformatf("rt%0d", i), 0, 0);
    end

    @(negedge clk);
    in_valid = 1'b1;
    in_key = to_port(~tv[0].key);
    in_data = rnd128();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("keyx_busy_before_reset", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    chk("midrun_reset_out_data", out_data, 128'h0);
    chk("midrun_reset_valid_ready_busy", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    @(negedge clk);
    rst = 1'b0;
    cv = 1'b0;
    run_block(tv[0].key, tv[0].ct, tv[0].pt, "after_reset_miss", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
